// File: rtl/mux2_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux2_rr_arbiter_pkg
//   Shared definitions for the two-requester round-robin mux arbiter:
//   state encodings, the default per-grant beat limit, the counter width
//   and a small helper that maps a requester index to its grant state.
// -----------------------------------------------------------------------------
package mux2_rr_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    // Default number of consecutive beats one grant may take while the
    // other requester is waiting.
    localparam int DEFAULT_MAX_HOLD = 4;

    // Width of the per-grant beat counter.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        GRANT0 = ST_GRANT0,
        GRANT1 = ST_GRANT1
    } arb_state_t;

    // Grant state owned by requester idx.
    function automatic arb_state_t grant_state(input logic idx);
        return idx ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux2.sv
// -----------------------------------------------------------------------------
// mux2_rr_arbiter_mux2
//   One-bit gate-level 2:1 multiplexer cell, replicated per data bit by the
//   arbiter top.
//   Ports:
//     i_a   - input selected when i_sel = 0
//     i_b   - input selected when i_sel = 1
//     i_sel - select
//     o_y   - selected output
// -----------------------------------------------------------------------------
module mux2_rr_arbiter_mux2 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);

    logic w_sel_n;
    logic w_a_term;
    logic w_b_term;

    assign w_sel_n  = ~i_sel;
    assign w_a_term = i_a & w_sel_n;
    assign w_b_term = i_b & i_sel;
    assign o_y      = w_a_term | w_b_term;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_rr_arbiter
//   Round-robin arbiter sharing one 2:1 data mux between two requesters and
//   presenting a single valid/ready stream downstream. A grant is limited to
//   MAX_HOLD consecutive beats while the other requester is waiting.
//
//   Handshake: a word transfers (a "beat") in any cycle where out_valid and
//   out_ready are both high; ack[sel] pulses in exactly that cycle. A
//   requester holds its data stable while req is high and ack is low, and
//   may drop req without an ack, in which case nothing transfers.
//
//   Ports:
//     clk       - clock, rising edge
//     rst       - asynchronous active-high reset
//     req[1:0]  - request per requester
//     data0     - requester 0 word
//     data1     - requester 1 word
//     ack[1:0]  - per-requester accept pulse (beat)
//     out_data  - muxed word (data0 when sel=0, data1 when sel=1)
//     out_valid - out_data is valid
//     out_ready - downstream accept
//     sel       - registered mux select
//     busy      - high in either grant state
// -----------------------------------------------------------------------------
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_sel;
    logic             w_sel_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_cur;
    logic             w_req_cur;
    logic             w_req_oth;
    logic             w_valid;
    logic             w_beat;
    logic             w_at_limit;

    // Owner of the current grant; only meaningful in a grant state.
    assign w_cur      = (r_state == GRANT1);
    assign w_req_cur  = req[w_cur];
    assign w_req_oth  = req[~w_cur];
    assign w_at_limit = (r_cnt == LIMIT);

    assign w_valid = ((r_state == GRANT0) & req[0]) |
                     ((r_state == GRANT1) & req[1]);
    assign w_beat  = w_valid & out_ready;

    assign out_valid = w_valid;
    assign sel       = r_sel;
    assign busy      = (r_state != IDLE);
    assign ack       = w_beat ? (r_sel ? 2'b10 : 2'b01) : 2'b00;

    // Data path: one mux cell per bit, all steered by the registered select.
    for (genvar g = 0; g < DATA_W; g++) begin : g_mux
        mux2_rr_arbiter_mux2 u_mux2 (
            .i_a   (data0[g]),
            .i_b   (data1[g]),
            .i_sel (r_sel),
            .o_y   (out_data[g])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            IDLE: begin
                // No beat is possible here; the grant takes effect next cycle.
                case (req)
                    2'b01: begin
                        w_state_nxt = GRANT0;
                        w_sel_nxt   = 1'b0;
                        w_cnt_nxt   = '0;
                    end
                    2'b10: begin
                        w_state_nxt = GRANT1;
                        w_sel_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                    end
                    2'b11: begin
                        // Tie goes to whoever did not hold the last grant.
                        w_state_nxt = grant_state(~r_last);
                        w_sel_nxt   = ~r_last;
                        w_cnt_nxt   = '0;
                    end
                    default: ;
                endcase
            end

            GRANT0, GRANT1: begin
                if (!w_req_cur) begin
                    // Holder withdrew: hand over directly or fall back to idle.
                    // A same-cycle limit expiry is irrelevant here.
                    w_last_nxt = w_cur;
                    w_cnt_nxt  = '0;
                    if (w_req_oth) begin
                        w_state_nxt = grant_state(~w_cur);
                        w_sel_nxt   = ~w_cur;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_beat && w_at_limit && w_req_oth) begin
                    // Beat budget spent with a competitor waiting: switch
                    // without an idle cycle.
                    w_last_nxt  = w_cur;
                    w_cnt_nxt   = '0;
                    w_state_nxt = grant_state(~w_cur);
                    w_sel_nxt   = ~w_cur;
                end else if (w_beat && !w_at_limit) begin
                    // At the limit with no competitor the count saturates.
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
